register_scoreboard: RTL and testbench
======================================

Name: register_scoreboard

Overview:
- Writer-side tracker for in-flight register results in the 5-stage ARM pipeline.
- ID records each issued instruction that will write a register; WB retires it.
- Pending state per architectural register (R0-R15) drives the stall decision for source operands in ID.
- Replaces distance-based comparison of EXE/MEM destinations with a counter-based scoreboard that tolerates variable-latency stages.

Parameters:
- NUM_REGS, 16, number of tracked architectural registers (index width fixed at 4 bits).
- CNT_W, 2, width of each per-register pending counter; maximum outstanding writes per register = 2^CNT_W - 1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  ID holds a valid instruction attempting to advance to EXE
- issue_wb_en  input  1  that instruction writes a register
- issue_dest  input  4  its destination register
- flush  input  1  ID instruction is being killed (branch taken); blocks issue this cycle
- src_1  input  4  first source register of ID instruction
- src_2  input  4  second source register of ID instruction
- two_src  input  1  src_2 is used
- wb_en  input  1  WB stage writes the register file this cycle
- wb_dest  input  4  WB destination register
- hazard_detected  output  1  stall ID/IF this cycle (combinational from state and inputs)
- pending_mask  output  16  bit i = counter[i] != 0 (registered state, no combinational input path)
- underflow_err  output  1  sticky: a retire hit a zero counter

Behaviour:
- Reset (rst=1 at clock edge): all counters = 0, underflow_err = 0.
  - Hence pending_mask = 0 and hazard_detected = 0 once inputs are idle.
  - rst overrides every simultaneous issue or retire.
- src_hit = counter[src_1] != 0 OR (two_src AND counter[src_2] != 0).
- sat_hit = issue_valid AND issue_wb_en AND counter[issue_dest] == 2^CNT_W - 1.
- hazard_detected = issue_valid AND (src_hit OR sat_hit). Zero when issue_valid = 0.
- issue_fire = issue_valid AND issue_wb_en AND NOT hazard_detected AND NOT flush.
- retire = wb_en.
- Per register r, on each clock edge:
  - issue_fire and retire both target r: counter unchanged (net zero).
  - Only issue_fire targets r: counter + 1.
  - Only retire targets r: counter - 1 if counter > 0; otherwise counter stays 0 and underflow_err is set to 1 (cleared only by rst).
- Latency:
  - An issued write is visible in pending_mask and hazard_detected the cycle after issue_fire.
  - A retire clears the hazard the cycle after wb_en (without the optional feature).
- Flush with issue_valid: no counter change; hazard_detected is still computed (the stall is harmless because ID is cleared).
- Counters never wrap. Saturation is prevented by sat_hit stalling the issue.
- R15 is tracked like any other register; no special case.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: a source whose counter is exactly 1 and which matches wb_dest with wb_en = 1 in the same cycle is not counted in src_hit. This models register-file write-before-read and removes one stall cycle.
  - Saturation check for the destination also uses the post-retire count.
- Undefined: src_hit uses registered counters only; the stall persists through the WB cycle.

Test Plan:
1. rst=1 for 2 cycles, then idle -> pending_mask=0x0000, hazard_detected=0, underflow_err=0.
2. Issue R3 write (issue_valid=1, issue_wb_en=1, issue_dest=3, src_1=1) -> next cycle pending_mask=0x0008. ID then presents src_1=3 -> hazard_detected=1 until wb_en with wb_dest=3. Clear is one cycle later without bypass; same cycle with SCOREBOARD_WB_BYPASS_EN.
3. Issue R5 three times on consecutive cycles with no retire (CNT_W=2) -> counter[5]=3. A fourth issue of R5 with unrelated sources -> hazard_detected=1 and counter stays 3. One retire of R5 -> the fourth issue fires next cycle.
4. Same cycle: issue_fire to R7 and wb_en to R7 with counter[7]=1 -> counter[7] remains 1 and pending_mask[7]=1.
5. two_src=0, src_2=4, counter[4]=1, src_1 clear -> hazard_detected=0. Set two_src=1 -> hazard_detected=1.
6. wb_en=1, wb_dest=9 with counter[9]=0 -> underflow_err=1 next cycle and counter[9]=0; underflow_err stays 1 until rst. Also: flush=1 with an otherwise firing issue -> no pending_mask change.

Source files
------------

// File: rtl/register_scoreboard.sv
// Counter-based register scoreboard: tracks in-flight writes per architectural register
// and raises a stall for RAW hazards or counter saturation. Option: SCOREBOARD_WB_BYPASS_EN.
module register_scoreboard #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [3:0]          issue_dest,
  input  logic                flush,
  input  logic [3:0]          src_1,
  input  logic [3:0]          src_2,
  input  logic                two_src,
  input  logic                wb_en,
  input  logic [3:0]          wb_dest,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                underflow_q, underflow_d;
  logic [CNT_W-1:0]    src1_cnt, src2_cnt, dest_cnt, dest_eff;
  logic                src1_busy, src2_busy, src_hit, sat_hit, issue_fire;
  logic [NUM_REGS-1:0] inc_vec, dec_vec;

  assign src1_cnt = cnt_q[src_1];
  assign src2_cnt = cnt_q[src_2];
  assign dest_cnt = cnt_q[issue_dest];

`ifdef SCOREBOARD_WB_BYPASS_EN
  // A lone outstanding write retiring this cycle is forwarded by the register file.
  assign src1_busy = (src1_cnt != '0) && !(wb_en && (wb_dest == src_1) && (src1_cnt == CntOne));
  assign src2_busy = (src2_cnt != '0) && !(wb_en && (wb_dest == src_2) && (src2_cnt == CntOne));
  assign dest_eff  = (wb_en && (wb_dest == issue_dest) && (dest_cnt != '0)) ?
                     dest_cnt - CntOne : dest_cnt;
`else
  assign src1_busy = (src1_cnt != '0);
  assign src2_busy = (src2_cnt != '0);
  assign dest_eff  = dest_cnt;
`endif

  assign src_hit         = src1_busy || (two_src && src2_busy);
  assign sat_hit         = issue_valid && issue_wb_en && (dest_eff == CntMax);
  assign hazard_detected = issue_valid && (src_hit || sat_hit);
  assign issue_fire      = issue_valid && issue_wb_en && !hazard_detected && !flush;

  assign inc_vec = issue_fire ? (NUM_REGS'(1) << issue_dest) : '0;
  assign dec_vec = wb_en ? (NUM_REGS'(1) << wb_dest) : '0;

  always_comb begin
    underflow_d = underflow_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CntOne;
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt_q[r] != '0);
    end
  end

  assign underflow_err = underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed plan items plus randomized traffic
// compared each cycle against an integer-count reference model.
module tb_register_scoreboard;

  localparam int CntMax = 3;

  logic        clk;
  logic        rst;
  logic        issue_valid, issue_wb_en, flush, two_src, wb_en;
  logic [3:0]  issue_dest, src_1, src_2, wb_dest;
  logic        hazard_detected, underflow_err;
  logic [15:0] pending_mask;

  int checks   = 0;
  int failures = 0;

  // Reference model: outstanding write count per register, sticky underflow flag.
  int cnt [16];
  bit uf;

  register_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_wb_en     (issue_wb_en),
    .issue_dest      (issue_dest),
    .flush           (flush),
    .src_1           (src_1),
    .src_2           (src_2),
    .two_src         (two_src),
    .wb_en           (wb_en),
    .wb_dest         (wb_dest),
    .hazard_detected (hazard_detected),
    .pending_mask    (pending_mask),
    .underflow_err   (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_busy(input int r);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_en && (int'(wb_dest) == r) && cnt[r] == 1) return 1'b0;
`endif
    return cnt[r] != 0;
  endfunction

  function automatic bit model_hazard();
    int d;
    bit hit;
    if (!issue_valid) return 1'b0;
    hit = model_busy(int'(src_1)) || (two_src && model_busy(int'(src_2)));
    d = cnt[issue_dest];
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_en && wb_dest == issue_dest && d > 0) d--;
`endif
    return hit || (issue_wb_en && d == CntMax);
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = (cnt[r] != 0);
    return m;
  endfunction

  task automatic idle();
    rst = 0; issue_valid = 0; issue_wb_en = 0; issue_dest = 0; flush = 0;
    src_1 = 0; src_2 = 0; two_src = 0; wb_en = 0; wb_dest = 0;
  endtask

  task automatic set_issue(input logic [3:0] dest, input logic [3:0] s1);
    issue_valid = 1; issue_wb_en = 1; issue_dest = dest; src_1 = s1;
  endtask

  // Check outputs at the falling edge, then advance model across the rising edge.
  task automatic tick();
    bit haz, fire, inc, dec;
    @(negedge clk);
    haz = model_hazard();
    check_eq("hazard", hazard_detected, haz);
    check_eq("pending_mask", pending_mask, model_mask());
    check_eq("underflow", underflow_err, uf);
    fire = issue_valid && issue_wb_en && !haz && !flush;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 16; r++) cnt[r] = 0;
      uf = 0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        inc = fire && (int'(issue_dest) == r);
        dec = wb_en && (int'(wb_dest) == r);
        if (inc && !dec) cnt[r]++;
        else if (dec && !inc) begin
          if (cnt[r] > 0) cnt[r]--;
          else uf = 1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    idle();
    for (int r = 0; r < 16; r++) cnt[r] = 0;
    uf = 0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_mask", pending_mask, 16'h0000);
    check_eq("rst_hazard", hazard_detected, 0);
    check_eq("rst_underflow", underflow_err, 0);
    tick();

    // Issue R3, then a dependent reader until WB of R3
    set_issue(4'd3, 4'd1); tick();
    idle(); #1;
    check_eq("r3_pending", pending_mask, 16'h0008);
    issue_valid = 1; src_1 = 3; #1;
    check_eq("r3_raw_stall", hazard_detected, 1);
    tick(); tick();
    wb_en = 1; wb_dest = 3; tick();
    wb_en = 0; tick();

    // Saturate R5, fourth issue stalls until a retire
    idle(); set_issue(4'd5, 4'd0);
    tick(); tick(); tick();
    #1;
    check_eq("r5_sat_stall", hazard_detected, 1);
    tick();
    wb_en = 1; wb_dest = 5; tick();
    wb_en = 0; tick();
    tick();

    // Net-zero issue and retire on R7
    idle(); set_issue(4'd7, 4'd0); tick();
    wb_en = 1; wb_dest = 7; tick();
    idle(); #1;
    check_eq("r7_net_zero", pending_mask[7], 1);
    wb_en = 1; wb_dest = 7; tick();

    // two_src gating on R4
    idle(); set_issue(4'd4, 4'd0); tick();
    idle(); issue_valid = 1; src_1 = 0; src_2 = 4; two_src = 0; #1;
    check_eq("two_src_off", hazard_detected, 0);
    tick();
    two_src = 1; #1;
    check_eq("two_src_on", hazard_detected, 1);
    tick();

    // Underflow on R9, and flush blocking an issue to R10
    idle(); wb_en = 1; wb_dest = 9; tick();
    idle(); #1;
    check_eq("underflow_set", underflow_err, 1);
    check_eq("r9_stays_zero", pending_mask[9], 0);
    set_issue(4'd10, 4'd0); flush = 1; tick();
    idle(); #1;
    check_eq("flush_no_issue", pending_mask[10], 0);
    check_eq("underflow_sticky", underflow_err, 1);
    tick();

    // Randomized traffic, mostly well-formed retires
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int wr;
      idle();
      if ($urandom_range(0, 299) == 0) rst = 1;
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wb_en = ($urandom_range(0, 3) != 0);
      issue_dest  = 4'($urandom_range(0, 7));
      src_1       = 4'($urandom_range(0, 15));
      src_2       = 4'($urandom_range(0, 15));
      two_src     = 1'($urandom);
      flush       = ($urandom_range(0, 7) == 0);
      wr = $urandom_range(0, 7);
      if (cnt[wr] > 0 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0)) begin
        wb_en = 1; wb_dest = 4'(wr);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
